// File: rtl/sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// sub_bytes_iter
//
// Iterative AES SubBytes engine. A 128-bit state is accepted over an
// in_valid/in_ready handshake, every byte is replaced by its forward S-box
// value LANES bytes per clock, and the finished state is offered over an
// out_valid/out_ready handshake.
//
// Parameters
//   LANES      S-box instances / bytes substituted per cycle (1,2,4,8,16)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_state holds a block to be substituted
//   in_ready   engine is idle and will accept a block
//   in_state   input state, byte 0 in bits [127:120]
//   out_valid  out_state holds a finished block
//   out_ready  consumer takes the finished block
//   out_state  substituted state, same byte order as in_state
//   busy       engine holds a block (substituting or waiting to hand off)
// ---------------------------------------------------------------------------
module sub_bytes_iter #(
   parameter int LANES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int STEPS = 16 / LANES;
   localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SUB  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_reg;
   state_t             state_next;
   logic [IDX_W-1:0]   idx_reg;
   logic [127:0]       data_reg;
   logic               last_step;

   logic [7:0]         lane_in  [LANES];
   logic [7:0]         lane_out [LANES];

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Forward S-box: multiplicative inverse (x^254, which maps 0 to 0)
   // followed by the FIPS-197 affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] pw;
      logic [7:0] inv;
      pw  = b;
      inv = 8'h01;
      // pw walks x^2, x^4, ... x^128; their product is x^254.
      for (int i = 1; i < 8; i++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
      return inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;
   endfunction

   // One S-box per lane; lane gi handles byte idx*LANES+gi of the state.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_in[gi]  = data_reg[127 - 8*(int'(idx_reg)*LANES + gi) -: 8];
         assign lane_out[gi] = sbox(lane_in[gi]);
      end
   endgenerate

   assign last_step = (idx_reg == IDX_W'(STEPS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (in_valid)  state_next = S_SUB;
         S_SUB:   if (last_step) state_next = S_DONE;
         S_DONE:  if (out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: load on accept, in-place substitution during SUB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_reg <= '0;
         idx_reg  <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  data_reg <= in_state;
                  idx_reg  <= '0;
               end
            end
            S_SUB: begin
               for (int l = 0; l < LANES; l++) begin
                  data_reg[127 - 8*(int'(idx_reg)*LANES + l) -: 8] <= lane_out[l];
               end
               // Wrap explicitly on the last step so that with a single step
               // the counter never points past byte 15.
               idx_reg <= last_step ? '0 : idx_reg + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign out_state = data_reg;
   assign out_valid = (state_reg == S_DONE);
   assign in_ready  = (state_reg == S_IDLE);
   assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_iter
//
// Directed bench for sub_bytes_iter. Four instances (LANES = 1, 2, 4, 16)
// share the input handshake; most steps observe the LANES=1 instance.
// ---------------------------------------------------------------------------
module tb_sub_bytes_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         out_ready;
   logic [127:0] in_state;

   logic         in_ready_w  [4];
   logic         out_valid_w [4];
   logic         busy_w      [4];
   logic [127:0] out_state_w [4];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dut
         localparam int LN = (gi == 3) ? 16 : (1 << gi);
         sub_bytes_iter #(.LANES(LN)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[gi]),
            .in_state  (in_state),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .out_state (out_state_w[gi]),
            .busy      (busy_w[gi])
         );
      end
   endgenerate

   logic [7:0] fwd_tbl [256];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sb(input logic [7:0] s);
      logic [7:0] t;
      t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      if (t == 8'h00) return 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (tb_mul(t, 8'(y)) == 8'h01) return 8'(y);
      end
      return 8'h00;
   endfunction

   function automatic logic [127:0] ref_state(input logic [127:0] d);
      logic [127:0] r;
      for (int b = 0; b < 16; b++) r[127 - 8*b -: 8] = fwd_tbl[d[127 - 8*b -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] inv_state(input logic [127:0] d);
      logic [127:0] r;
      for (int b = 0; b < 16; b++) r[127 - 8*b -: 8] = inv_sb(d[127 - 8*b -: 8]);
      return r;
   endfunction

   function automatic int lanes_of(input int i);
      return (i == 3) ? 16 : (1 << i);
   endfunction

   task automatic accept(input logic [127:0] d);
      in_state = d;
      in_valid = 1'b1;
      check("in_ready_before_accept", in_ready_w[0], 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("busy_after_accept", busy_w[0], 1'b1);
   endtask

   task automatic wait_valid(input int i, output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (out_valid_w[i]) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) begin
         tests++;
         fails++;
         $error("FAIL wait_valid timeout on instance %0d", i);
      end
   endtask

   localparam logic [127:0] SANITY_IN  = 128'h00015310ff0000000000000000000000;
   localparam logic [127:0] SANITY_OUT = 128'h637cedca166363636363636363636363;
   localparam logic [127:0] FIPS_IN    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT   = 128'hd42711aee0bf98f1b8b45de51e415230;

   initial begin
      int           lat;
      int           lat_a [4];
      logic [127:0] res_a [4];
      logic [127:0] blk;
      logic [127:0] held;
      int           cnt;
      int           prev_acc;
      int           acc_cyc;

      for (int s = 0; s < 256; s++) fwd_tbl[inv_sb(8'(s))] = 8'(s);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_state  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid_w[0], 1'b0);
      check("reset_out_state", out_state_w[0], 128'h0);
      check("reset_in_ready", in_ready_w[0], 1'b1);
      check("reset_busy", busy_w[0], 1'b0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;

      accept(SANITY_IN);
      wait_valid(0, lat);
      check("sanity_latency", lat, 16);
      check("sanity_data", out_state_w[0], SANITY_OUT);
      $display("[TB] sanity in=%h out=%h lat=%0d", SANITY_IN, out_state_w[0], lat);
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) begin
         lat_a[i] = -1;
         res_a[i] = '0;
      end
      accept(FIPS_IN);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            if (out_valid_w[i] && lat_a[i] < 0) begin
               lat_a[i] = k;
               res_a[i] = out_state_w[i];
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         check("fips_latency", lat_a[i], 16 / lanes_of(i));
         check("fips_data", res_a[i], FIPS_OUT);
         $display("[TB] fips lanes=%0d out=%h lat=%0d", lanes_of(i), res_a[i], lat_a[i]);
      end

      out_ready = 1'b0;
      accept(FIPS_IN);
      wait_valid(0, lat);
      check("bp_latency", lat, 16);
      held = out_state_w[0];
      check("bp_data", held, FIPS_OUT);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         in_valid = (k == 3);
         in_state = ~FIPS_IN;
         @(posedge clk); #1;
         if (!out_valid_w[0] || out_state_w[0] !== held || in_ready_w[0]) cnt++;
      end
      in_valid = 1'b0;
      check("bp_hold_violations", cnt, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_out_valid", out_valid_w[0], 1'b0);
      check("bp_release_in_ready", in_ready_w[0], 1'b1);
      check("bp_release_busy", busy_w[0], 1'b0);
      $display("[TB] backpressure out=%h held 10 cycles", held);

      accept(FIPS_IN);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_out_valid", out_valid_w[0], 1'b0);
      check("midrst_out_state", out_state_w[0], 128'h0);
      check("midrst_in_ready", in_ready_w[0], 1'b1);
      check("midrst_busy", busy_w[0], 1'b0);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_valid_w[0]) cnt++;
      end
      check("midrst_no_pulse", cnt, 0);
      accept(SANITY_IN);
      wait_valid(0, lat);
      check("midrst_next_latency", lat, 16);
      check("midrst_next_data", out_state_w[0], SANITY_OUT);
      $display("[TB] after reset in=%h out=%h lat=%0d", SANITY_IN, out_state_w[0], lat);
      @(posedge clk); #1;

      for (int b = 0; b < 16; b++) begin
         for (int j = 0; j < 16; j++) blk[127 - 8*j -: 8] = 8'(b*16 + j);
         accept(blk);
         wait_valid(0, lat);
         check("roundtrip_latency", lat, 16);
         check("roundtrip_data", inv_state(out_state_w[0]), blk);
         $display("[TB] roundtrip in=%h out=%h", blk, out_state_w[0]);
         @(posedge clk); #1;
      end

      prev_acc = -1;
      in_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         blk = {$urandom, $urandom, $urandom, $urandom};
         in_state = blk;
         cnt = 0;
         while (!in_ready_w[0] && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
         end
         check("stream_ready_timeout", in_ready_w[0], 1'b1);
         @(posedge clk); #1;
         acc_cyc = cyc;
         if (prev_acc >= 0) begin
            check("stream_accept_gap", acc_cyc - prev_acc, 18);
         end
         prev_acc = acc_cyc;
         wait_valid(0, lat);
         check("stream_data", out_state_w[0], ref_state(blk));
         $display("[TB] stream %0d in=%h out=%h lat=%0d", n, blk, out_state_w[0], lat);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative AES SubBytes engine for the encryption datapath: accepts a 128-bit state over a valid/ready handshake and substitutes every byte through the forward FIPS-197 S-box, `LANES` bytes per clock. It returns the result on a second valid/ready handshake. It is the forward counterpart of the decryption-side InvSBox: feeding each output byte through InvSBox returns the original input byte. It sits between AddRoundKey and ShiftRows in the encryption round controller, trading area (LANES S-box instances instead of 16) for latency.

## Interface
- `LANES`, default 1: number of S-box instances and bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16. `STEPS = 16/LANES`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: `in_state` is valid.
- `in_ready` out 1: engine can accept a block.
- `in_state` in 128: input state. Byte i occupies bits [127-8i -: 8], so byte 0 is the MSB byte (FIPS-197 column-major order).
- `out_valid` out 1: `out_state` holds a finished block.
- `out_ready` in 1: consumer takes the block.
- `out_state` out 128: substituted state, same byte order as `in_state`.
- `busy` out 1: engine is in SUB or DONE.

## Operation
- FSM states and transitions:
  - IDLE → SUB on `in_valid & in_ready`.
  - SUB → DONE when the last step completes.
  - DONE → IDLE on `out_valid & out_ready`.
- Acceptance, in IDLE only: on the accept edge, load `in_state` into the internal state register and clear the step counter `idx` to 0.
- SUB, each cycle:
  - Bytes `idx*LANES` through `idx*LANES+LANES-1` of the state register pass through the S-boxes and are written back in place. `idx` then increments.
  - When `idx == STEPS-1`, the write-back edge also moves the FSM to DONE.
- S-box mapping is the standard FIPS-197 forward table, purely combinational per lane. The implementation may use a 256-entry case table or GF(2^8) inversion plus the affine map.
- Output signals:
  - `out_state` is driven from the state register and is meaningful only while `out_valid=1`.
  - `out_valid` = (state == DONE).
  - `in_ready` = (state == IDLE).
  - `busy` = (state != IDLE).
- DONE holds `out_state` stable, and `out_valid` stays asserted, until `out_ready` is sampled high. Backpressure of any length is legal.
- There is no same-cycle release and accept: a new block is accepted only from IDLE, so at least one IDLE cycle separates consecutive blocks.
- `in_valid` while not in IDLE is ignored. `in_state` changes during SUB have no effect.
- `out_ready` outside DONE is ignored.
- `idx` width is `max(1, clog2(STEPS))`. With `LANES=16`, SUB lasts exactly one cycle.

## Timing
- Reset values: state IDLE, `idx` 0, state register 0. Resulting outputs: `out_valid` 0, `out_state` 0, `in_ready` 1, `busy` 0.
- Latency: an accept at edge T gives `out_valid=1` after edge T+STEPS. That is 16 cycles for `LANES=1` and 4 cycles for `LANES=4`.
- Handshake: the earliest release is edge T+STEPS+1 (with `out_ready=1`). The earliest next accept is edge T+STEPS+2. Throughput is 1 block per STEPS+2 cycles.
- Reset mid-operation: `rst_n=0` sampled at any edge, in any state, forces IDLE and all reset values at that edge. A partially substituted block is discarded, and no `out_valid` pulse is produced for it.
- `rst_n=0` has priority over simultaneous `in_valid`, `out_ready` and step advance.
- `in_valid` and `out_ready` are sampled only on clock edges. Asynchronous glitches are outside this contract.

## Test plan
- Single-byte sanity, `LANES=1`: input bytes 00,01,53,10,ff followed by zeros. Required output bytes 63,7c,ed,ca,16, then 63 for every zero byte. `out_valid` rises exactly 16 cycles after accept.
- FIPS-197 round-1 vector: input 193de3bea0f4e22b9ac68d2ae9f84808. Required output d42711aee0bf98f1b8b45de51e415230. Repeat for `LANES` = 1, 2, 4, 16; the latency must equal 16/`LANES`.
- Backpressure: hold `out_ready=0` for 10 cycles after `out_valid`. Required: `out_state` stable and `out_valid=1` throughout. Release at the next edge; `in_ready=1` the following cycle. A second `in_valid` pulse during DONE must not be accepted.
- Reset mid-block: accept a block, then assert `rst_n=0` at step 7. Required: the next cycle shows `out_valid=0`, `out_state=0`, `in_ready=1`. A subsequent block completes correctly with full latency.
- Exhaustive round trip: 16 blocks covering bytes 00..ff, each output byte fed through InvSBox. Required: the original byte is recovered for all 256 values.
- Back-to-back streaming: 100 random blocks with `out_ready` tied to 1. Required: results match a reference S-box model in order, with exactly STEPS+2 cycles between accepts.
